seq_mult4_ctrl: RTL
===================

Name: seq_mult4_ctrl

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier.
- Sits directly upstream of the team's 4-bit ripple-carry adder block and consumes its result.
- Owns the operand, accumulator and multiplier registers and the control FSM. It drives the adder's A/B/Cin inputs and takes back Sout/Cout on every iteration.
- Produces an 8-bit product with a start/busy/done handshake.

Parameters:
- WIDTH, 4: operand width. Must equal the external adder width. Only 4 is supported in this release.
- CNT_W, 2: iteration counter width, clog2(WIDTH).

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  Request to multiply. Sampled only in IDLE.
- multiplicand  in  4  Operand M, captured on the accepted start edge.
- multiplier  in  4  Operand Q, captured on the accepted start edge.
- busy  out  1  High while in CALC.
- done  out  1  One-cycle pulse: the product register has just been updated.
- product  out  8  Registered result {ACC,Q}. Holds its value until the next completion.
- add_a  out  4  To adder A. Equals ACC register (combinational).
- add_b  out  4  To adder B. Equals M when Q[0]=1, else 4'b0000.
- add_cin  out  1  To adder Cin. Tied to 0.
- add_sum  in  4  From adder Sout.
- add_cout  in  1  From adder Cout.

Behaviour:
- Internal registers: M[3:0], ACC[3:0], Q[3:0], cnt[1:0], state, product[7:0], done.
- FSM states: IDLE, CALC, DONE.
- Reset: takes priority over everything, including mid-operation.
  - state=IDLE; M, ACC, Q, cnt=0; product=8'h00; done=0; busy=0.
  - Any in-progress multiply is abandoned and no done is produced.
- IDLE:
  - start=1 at an edge: M<=multiplicand, Q<=multiplier, ACC<=0, cnt<=0, state<=CALC.
  - start=0: hold.
- CALC, one iteration per clock:
  - Adder returns {add_cout,add_sum} = ACC + (Q[0]?M:0).
  - At the edge: {ACC,Q} <= {add_cout,add_sum,Q} >> 1. That is, ACC<={add_cout,add_sum[3:1]} and Q<={add_sum[0],Q[3:1]}.
  - cnt<=cnt+1.
  - When cnt==3 at the edge, also do product<={new ACC,new Q}, done<=1, state<=DONE.
- DONE: done=1 for exactly this one cycle. Next edge: done<=0, state<=IDLE.
- busy is combinational: (state==CALC).
- Latency:
  - start accepted at edge k; CALC occupies cycles k..k+3.
  - product is updated and done rises at edge k+4.
  - Earliest next accept is edge k+6 (IDLE reached at k+5).
- start while in CALC or DONE is ignored. It is not queued, and operands are not re-captured.
- Operand inputs may change freely after the accepting edge without effect.
- Arithmetic:
  - Unsigned only. The carry out of each add is shifted into ACC[3], so no overflow is possible.
  - 15x15 = 225 fits in 8 bits.
- The adder path is purely combinational. add_sum/add_cout must settle within one clock; there is no multicycle path.
- product is unchanged during CALC and reflects only the last completed multiply.

Test Plan:
- Reset, then M=4'hF, Q=4'hF, start 1 cycle:
  - busy high for exactly 4 cycles.
  - At edge k+4: product=8'hE1 (225), done=1 for one cycle.
  - add_cout=1 observed on at least one CALC cycle.
- M=9, Q=6:
  - add_b sequence over CALC is 0,9,9,0.
  - product=8'h36 (54).
- M=0, Q=4'hB, then M=4'hB, Q=0:
  - both give product=8'h00 with done pulse.
  - add_b=0 on every cycle of the second case.
- M=3, Q=5 started; start held high with M=7, Q=7 through CALC and DONE:
  - result is product=8'h0F (15), the second request is ignored while busy.
  - start still high in the following IDLE cycle is accepted, and the next result is 8'h31 (49).
- M=5, Q=5 started; reset asserted at the 2nd CALC cycle:
  - next cycle state=IDLE, busy=0, product=8'h00, and no done pulse ever appears.
  - A new start with M=2, Q=3 gives product=8'h06.
- Back-to-back starts, first M=1, Q=8, then M=4'hF, Q=1:
  - products 8'h08 then 8'h0F.
  - The first product holds its value until the second done edge.

Source files
------------

// File: rtl/seq_mult4_ctrl.sv
// seq_mult4_ctrl: sequential unsigned shift-and-add multiplier controller.
// Holds the operand (M), accumulator (ACC) and multiplier (Q) registers and
// the control FSM. An external ripple-carry adder does the per-iteration add:
// this block drives its A/B/Cin and takes back Sout/Cout every CALC cycle.
//
// Ports:
//   clk, reset         - single clock, synchronous active-high reset
//   start              - multiply request, sampled only in IDLE
//   multiplicand       - operand M, captured on the accepted start edge
//   multiplier         - operand Q, captured on the accepted start edge
//   busy               - high while iterating (CALC)
//   done               - one-cycle pulse after product has been updated
//   product            - registered {ACC,Q} result of the last completed multiply
//   add_a/add_b/add_cin- to the external adder (ACC, Q[0]?M:0, 0)
//   add_sum/add_cout   - from the external adder
module seq_mult4_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q_reg;
  logic [CNT_W-1:0] cnt;

  // Post-shift values of {ACC,Q}: the adder carry lands in ACC's MSB, so the
  // shifted-in bit never overflows.
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    acc_next = {add_cout, add_sum[WIDTH-1:1]};
    q_next   = {add_sum[0], q_reg[WIDTH-1:1]};
  end

  assign busy    = (state == CALC);
  assign add_a   = acc;
  assign add_b   = q_reg[0] ? m_reg : '0;
  assign add_cin = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          q_reg <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            product <= {acc_next, q_next};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
